// File: rtl/stream_cipher_sched_pkg.sv
// Shared types and constants for the chaotic-map keystream scheduler and its
// internal-state block.
package stream_cipher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEED = 3'd2,
        ST_WARM = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int NS_DEF    = 4;
    localparam int CNT_W_DEF = 16;

    // Internal-state mux select: seed from key setup or iterate the map.
    localparam logic S_SEED = 1'b0;
    localparam logic S_ITER = 1'b1;

endpackage

// File: rtl/stream_cipher_sched_if.sv
// Control/handshake bus between the scheduler and its driver/consumer.
interface stream_cipher_sched_if
    import stream_cipher_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             rekey;
    logic [CNT_W-1:0] num_words;
    logic             ks_ready;
    logic             read0;
    logic             s;
    logic             en1;
    logic             ks_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output start, rekey, num_words, ks_ready,
        input  read0, s, en1, ks_valid, busy, done, word_cnt
    );

    modport slave (
        input  start, rekey, num_words, ks_ready,
        output read0, s, en1, ks_valid, busy, done, word_cnt
    );
endinterface

// File: rtl/stream_cipher_sched_cnt.sv
// Generic up-counter with synchronous clear (priority over enable) and a
// maskable terminal-count flag.
module stream_cipher_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         term_en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = term_en && (cnt_q == term);
endmodule

// File: rtl/stream_cipher_sched.sv
// Sequencer for the keystream datapath: key/IV load, seed, NS discarded
// warm-up iterations, then a bounded or unbounded valid/ready word stream.
module stream_cipher_sched
    import stream_cipher_pkg::*;
#(
    parameter int NS    = NS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_cipher_sched_if.slave  bus
);
    localparam int WW = $clog2(NS + 1);
    localparam logic [WW-1:0] WARM_TERM = WW'(NS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] nw_q, nw_d;
    logic             rekey_ok, accept, start_ok;
    logic             warm_tc, word_tc;
    logic [WW-1:0]    warm_cnt;

    assign rekey_ok = bus.rekey &&
                      (state_q == ST_SEED || state_q == ST_WARM || state_q == ST_RUN);
    assign accept   = (state_q == ST_RUN) && bus.ks_ready;
    assign start_ok = (state_q == ST_IDLE) && bus.start;

    always_comb begin
        state_d = state_q;
        nw_d    = nw_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                nw_d    = bus.num_words;
                state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_SEED;
            ST_SEED: state_d = ST_WARM;
            ST_WARM: if (warm_tc) state_d = ST_RUN;
            ST_RUN:  if (accept && word_tc) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Rekey overrides any same-cycle accept or completion.
        if (rekey_ok)
            state_d = ST_LOAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            nw_q    <= '0;
        end else begin
            state_q <= state_d;
            nw_q    <= nw_d;
        end
    end

    stream_cipher_cnt #(.W(WW)) u_warm_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (state_q == ST_SEED),
        .en      (state_q == ST_WARM),
        .term_en (1'b1),
        .term    (WARM_TERM),
        .cnt     (warm_cnt),
        .tc      (warm_tc)
    );

    // num_words == 0 disables the terminal so the count simply wraps.
    stream_cipher_cnt #(.W(CNT_W)) u_word_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (start_ok || rekey_ok),
        .en      (accept && !rekey_ok),
        .term_en (nw_q != '0),
        .term    (nw_q - CNT_W'(1)),
        .cnt     (bus.word_cnt),
        .tc      (word_tc)
    );

    assign bus.read0    = (state_q == ST_LOAD);
    assign bus.s        = (state_q == ST_WARM || state_q == ST_RUN) ? S_ITER : S_SEED;
    assign bus.en1      = !rekey_ok && ((state_q == ST_SEED) || (state_q == ST_WARM) ||
                                        accept);
    assign bus.ks_valid = (state_q == ST_RUN);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);

    logic unused_ok;
    assign unused_ok = ^warm_cnt;
endmodule

// File: doc/stream_cipher_sched.md
Name: stream_cipher_sched

Overview:
- Sequencing controller for the chaotic-map keystream datapath: key/IV register, key setup, internal state, output function.
- Orders the key/IV load, seeds the internal state, and runs NS discarded warm-up iterations.
- Then delivers a bounded or unbounded run of 32-bit keystream words over a valid/ready handshake.
- Stalls the internal-state update while the consumer is not ready. Supports an abort-and-rekey request.

Parameters:
- NS, 4, number of warm-up iterations discarded before the first valid word (1..255).
- CNT_W, 16, width of the word-count request and the word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a session; sampled only in IDLE.
- rekey  in  1  abort the current session and reload key/IV; honoured in SEED, WARM and RUN.
- num_words  in  CNT_W  words to deliver; latched when start is accepted; 0 means unbounded.
- ks_ready  in  1  consumer accepts the keystream word this cycle.
- read0  out  1  key/IV register load strobe.
- s  out  1  internal-state mux select: 0 = seed from key setup (Xp0/Xs0), 1 = iterate.
- en1  out  1  internal-state update enable.
- ks_valid  out  1  the current keystream output is a valid word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a bounded session completes.
- word_cnt  out  CNT_W  words accepted in the current session.

Behaviour:
- Reset values (asynchronous, reset=0): state=IDLE, all outputs 0, internal counters 0, latched num_words 0.
- States are IDLE, LOAD, SEED, WARM, RUN, DONE. Outputs are decoded from the state, except en1 in RUN.
- IDLE: all outputs 0. start=1 latches num_words, clears word_cnt, and moves to LOAD.
- LOAD: read0=1 for exactly one cycle, then SEED.
- SEED: s=0, en1=1 for exactly one cycle, loading the state from key setup. Clears the warm counter. Then WARM.
- WARM: s=1, en1=1 every cycle, ks_valid=0. The warm counter increments each cycle. After NS cycles, move to RUN, so the first valid word appears NS+3 cycles after start.
- RUN: s=1, ks_valid=1. Combinationally, en1 = ks_ready.
  - Accept means ks_valid and ks_ready are both high; word_cnt increments on each accept.
  - Without ready, the state holds and the keystream word is stable.
  - Bounded session: an accept with word_cnt == latched num_words-1 moves to DONE. word_cnt ends equal to num_words.
  - num_words=0: RUN continues until rekey. word_cnt wraps modulo 2^CNT_W with no other effect.
- DONE: done=1, busy=1 for one cycle, then IDLE. word_cnt holds its value until the next start.
- Rekey in SEED, WARM or RUN:
  - Next state is LOAD and word_cnt clears.
  - The same num_words is kept.
  - ks_valid drops the next cycle, and en1 is 0 in the rekey cycle.
  - rekey has priority over an accept in the same cycle: that word still counts as delivered to the consumer, but word_cnt is cleared.
- rekey in IDLE, LOAD or DONE is ignored.
- start outside IDLE is ignored. start and rekey together in IDLE: start wins.
- Reset asserted mid-operation returns to IDLE immediately. No output glitches beyond the asynchronous clear.
- The warm counter is ceil(log2(NS+1)) bits wide. NS=1 gives one WARM cycle.

Decomposition:
- Shared package stream_cipher_pkg holds:
  - the state enum (IDLE..DONE, 3-bit encoding);
  - the default NS=4 and CNT_W=16 constants;
  - S_SEED=0 and S_ITER=1 select constants, shared with the internal-state block.
- One sub-module, stream_cipher_cnt: a generic enable/clear/terminal-count counter. Instantiated twice: the warm counter (terminal NS-1) and the word counter (terminal num_words-1, terminal disabled when num_words=0).

Test Plan:
- Reset, then start with num_words=3 and ks_ready tied 1:
  - read0 high in cycle 1; s=0/en1=1 in cycle 2; en1 in cycles 3-6;
  - ks_valid in cycles 7-9; done pulse in cycle 10; word_cnt=3; busy low in cycle 11.
- num_words=2 with ks_ready toggling 1,0,0,1: en1 follows ks_ready in RUN; the keystream holds during stalls; exactly 2 accepts, then done.
- num_words=0 with ks_ready=1 for 20 RUN cycles: no done, word_cnt=20; rekey then gives LOAD next, ks_valid=0, word_cnt=0.
- rekey in the 2nd WARM cycle: returns to LOAD, then SEED, then a full NS=4 warm-up, then RUN.
- start pulses during RUN and DONE: no effect on state or counters. Reset asserted in RUN: all outputs 0 asynchronously, state IDLE.
- rekey and an accept in the same cycle with num_words=1: no done pulse, word_cnt=0, state LOAD.
